// File: rtl/i2c_byte_transmitter_pkg.sv
// Shared TX definitions for the I2C peripheral: state encodings, ACK/NACK line levels
// and the open-drain drive helper used by the byte transmitter.
package i2c_byte_transmitter_pkg;

   localparam int I2C_TX_WIDTH = 8;

   typedef enum logic [1:0] {
      TX_IDLE     = 2'd0,
      TX_SEND     = 2'd1,
      TX_ACK_WAIT = 2'd2,
      TX_ACK_HOLD = 2'd3
   } tx_state_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Open-drain: a 0 bit is sent by pulling SDA low, a 1 bit by releasing it.
   function automatic logic sda_drive(input logic bit_val);
      return ~bit_val;
   endfunction

endpackage

// File: rtl/i2c_byte_transmitter.sv
// Peripheral-side I2C byte transmitter: shifts a byte out MSB first on SCL falls, then samples ACK.
// Optional clock stretching after an ACKed byte is enabled with `define I2C_TX_CLK_STRETCH_EN.
module i2c_byte_transmitter
   import i2c_byte_transmitter_pkg::*;
#(
   parameter int WIDTH = I2C_TX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             scl_fall,
   input  logic             scl_rise,
   input  logic             sda_in,
   input  logic             abort,
   output logic             sda_oe,
   output logic             busy,
   output logic             done,
   output logic             ack
`ifdef I2C_TX_CLK_STRETCH_EN
   ,
   output logic             scl_oe
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   tx_state_e        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_q, ack_d;
`ifdef I2C_TX_CLK_STRETCH_EN
   logic             scl_oe_q, scl_oe_d;
`endif

   // Next-state and registered-output decode; abort overrides every strobe.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      sda_oe_d  = sda_oe_q;
      ack_d     = ack_q;
      done_d    = 1'b0;
`ifdef I2C_TX_CLK_STRETCH_EN
      scl_oe_d  = scl_oe_q;
`endif
      if (abort) begin
         state_d  = TX_IDLE;
         sda_oe_d = 1'b0;
`ifdef I2C_TX_CLK_STRETCH_EN
         scl_oe_d = 1'b0;
`endif
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (start) begin
                  shift_d   = data_in;
                  bit_cnt_d = {CNT_W{1'b0}};
                  ack_d     = 1'b0;
                  sda_oe_d  = sda_drive(data_in[WIDTH-1]);
                  state_d   = TX_SEND;
`ifdef I2C_TX_CLK_STRETCH_EN
                  scl_oe_d  = 1'b0;
`endif
               end else begin
`ifdef I2C_TX_CLK_STRETCH_EN
                  // Hold SCL low once an ACKed byte completes, until the next byte is loaded.
                  if (done_q && ack_q) begin
                     scl_oe_d = 1'b1;
                  end else begin
                     scl_oe_d = scl_oe_q;
                  end
`else
                  state_d = TX_IDLE;
`endif
               end
            end
            TX_SEND: begin
               if (scl_fall) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     sda_oe_d = 1'b0;
                     state_d  = TX_ACK_WAIT;
                  end else begin
                     // Rotate rather than shift so every stored bit stays live; only the MSB is sent.
                     shift_d   = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
                     bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                     sda_oe_d  = sda_drive(shift_q[WIDTH-2]);
                  end
               end else begin
                  state_d = TX_SEND;
               end
            end
            TX_ACK_WAIT: begin
               if (!scl_fall && scl_rise) begin
                  ack_d   = (sda_in == I2C_ACK);
                  state_d = TX_ACK_HOLD;
               end else begin
                  state_d = TX_ACK_WAIT;
               end
            end
            TX_ACK_HOLD: begin
               if (scl_fall) begin
                  done_d  = 1'b1;
                  state_d = TX_IDLE;
               end else begin
                  state_d = TX_ACK_HOLD;
               end
            end
            default: begin
               sda_oe_d = 1'b0;
               state_d  = TX_IDLE;
            end
         endcase
      end
      busy_d = (state_d != TX_IDLE);
   end

   // State and output registers; reset releases SDA without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TX_IDLE;
         shift_q   <= {WIDTH{1'b0}};
         bit_cnt_q <= {CNT_W{1'b0}};
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
`ifdef I2C_TX_CLK_STRETCH_EN
         scl_oe_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_q     <= ack_d;
`ifdef I2C_TX_CLK_STRETCH_EN
         scl_oe_q  <= scl_oe_d;
`endif
      end
   end

   assign sda_oe = sda_oe_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign ack    = ack_q;
`ifdef I2C_TX_CLK_STRETCH_EN
   assign scl_oe = scl_oe_q;
`endif

endmodule

// File: tb/tb_i2c_byte_transmitter.sv
// Self-checking bench for i2c_byte_transmitter: a bit-index model of the wire is compared every
// cycle, plus literal expectations for each directed scenario. Stretch test needs I2C_TX_CLK_STRETCH_EN.
module tb_i2c_byte_transmitter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       scl_fall = 1'b0;
   logic       scl_rise = 1'b0;
   logic       sda_in = 1'b1;
   logic       abort = 1'b0;
   logic       sda_oe, busy, done, ack;
`ifdef I2C_TX_CLK_STRETCH_EN
   logic       scl_oe;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit cmp_en = 1'b0;

   i2c_byte_transmitter #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .scl_fall(scl_fall), .scl_rise(scl_rise), .sda_in(sda_in), .abort(abort),
      .sda_oe(sda_oe), .busy(busy), .done(done), .ack(ack)
`ifdef I2C_TX_CLK_STRETCH_EN
      , .scl_oe(scl_oe)
`endif
   );

   always #5 clk = ~clk;

   // Model: phase -1 idle, 0..7 bit index on the wire, 8 waiting for ACK rise, 9 waiting for last fall.
   int         m_phase = -1;
   logic [7:0] m_byte = 8'h00;
   logic       m_sda = 1'b0;
   logic       m_ack = 1'b0;
   logic       m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= -1; m_byte <= 8'h00; m_sda <= 1'b0; m_ack <= 1'b0; m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (abort) begin
            m_phase <= -1; m_sda <= 1'b0;
         end else if (m_phase < 0) begin
            if (start) begin
               m_byte <= data_in; m_phase <= 0; m_ack <= 1'b0; m_sda <= ~data_in[7];
            end
         end else if (scl_fall) begin
            if (m_phase < 7) begin
               m_phase <= m_phase + 1; m_sda <= ~m_byte[6 - m_phase];
            end else if (m_phase == 7) begin
               m_phase <= 8; m_sda <= 1'b0;
            end else if (m_phase == 9) begin
               m_phase <= -1; m_done <= 1'b1;
            end
         end else if (scl_rise && m_phase == 8) begin
            m_ack <= ~sda_in; m_phase <= 9;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_sda_oe", {7'd0, sda_oe}, {7'd0, m_sda});
         chk("cyc_busy",   {7'd0, busy},   {7'd0, (m_phase != -1)});
         chk("cyc_done",   {7'd0, done},   {7'd0, m_done});
         chk("cyc_ack",    {7'd0, ack},    {7'd0, m_ack});
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [7:0] d);
      data_in = d; start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse(input logic lvl, output logic seen);
      seen = sda_oe;
      sda_in = lvl; scl_rise = 1'b1; tick();
      scl_rise = 1'b0; tick();
      scl_fall = 1'b1; tick();
      scl_fall = 1'b0; tick();
      sda_in = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ack_lvl, output logic [7:0] seen);
      logic s;
      do_start(d); tick();
      for (int i = 0; i < 8; i++) begin
         pulse(1'b1, s); seen[7-i] = s;
      end
      pulse(ack_lvl, s);
      tick(); tick();
   endtask

   initial begin
      logic [7:0] seen;
      logic       s;
      repeat (3) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
      chk("rst_busy",   {7'd0, busy},   8'h00);
      chk("rst_done",   {7'd0, done},   8'h00);
      chk("rst_ack",    {7'd0, ack},    8'h00);
      rst_n = 1'b1; tick();

      // 1: A5 ACKed
      send_byte(8'hA5, 1'b0, seen);
      chk("t1_bits", seen, 8'h5A);
      chk("t1_ack", {7'd0, ack}, 8'h01);
      chk("t1_done_cnt", done_cnt[7:0], 8'd1);

      // 2: FF NACKed
      send_byte(8'hFF, 1'b1, seen);
      chk("t2_bits", seen, 8'h00);
      chk("t2_ack", {7'd0, ack}, 8'h00);
      chk("t2_done_cnt", done_cnt[7:0], 8'd2);
      chk("t2_busy", {7'd0, busy}, 8'h00);

      // 3: abort after 3rd fall, then 81
      do_start(8'h00); tick();
      for (int i = 0; i < 3; i++) pulse(1'b1, s);
      chk("t3_pre_abort_oe", {7'd0, sda_oe}, 8'h01);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t3_abort_oe", {7'd0, sda_oe}, 8'h00);
      chk("t3_abort_busy", {7'd0, busy}, 8'h00);
      tick();
      chk("t3_no_done", done_cnt[7:0], 8'd2);
      send_byte(8'h81, 1'b0, seen);
      chk("t3_bits", seen, 8'h7E);
      chk("t3_ack", {7'd0, ack}, 8'h01);
      chk("t3_done_cnt", done_cnt[7:0], 8'd3);

      // 4: start with 3C while C3 in flight
      do_start(8'hC3); tick();
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            do_start(8'h3C); tick();
         end
         pulse(1'b1, s); seen[7-i] = s;
      end
      pulse(1'b0, s); tick(); tick();
      chk("t4_bits", seen, 8'h3C);
      chk("t4_done_cnt", done_cnt[7:0], 8'd4);
      chk("t4_ack", {7'd0, ack}, 8'h01);

      // 5: reset at bit 5 of 00, checked before any clock edge
      do_start(8'h00); tick();
      for (int i = 0; i < 5; i++) pulse(1'b1, s);
      chk("t5_pre_oe", {7'd0, sda_oe}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_oe",   {7'd0, sda_oe}, 8'h00);
      chk("t5_async_busy", {7'd0, busy},   8'h00);
      chk("t5_async_done", {7'd0, done},   8'h00);
      chk("t5_async_ack",  {7'd0, ack},    8'h00);
      @(posedge clk); #1 rst_n = 1'b1; tick();
      chk("t5_no_done", done_cnt[7:0], 8'd4);

      // start and abort together: abort wins; strobes in IDLE ignored
      data_in = 8'h55; start = 1'b1; abort = 1'b1; tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", {7'd0, busy}, 8'h00);
      scl_fall = 1'b1; scl_rise = 1'b1; tick();
      scl_fall = 1'b0; scl_rise = 1'b0; tick();
      chk("idle_strobe_busy", {7'd0, busy}, 8'h00);

      // simultaneous rise+fall in ACK slot: rise dropped, the later real pulse NACKs
      do_start(8'hF0); tick();
      for (int i = 0; i < 8; i++) pulse(1'b1, s);
      sda_in = 1'b0; scl_rise = 1'b1; scl_fall = 1'b1; tick();
      scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1; tick();
      chk("both_busy", {7'd0, busy}, 8'h01);
      pulse(1'b1, s); tick(); tick();
      chk("both_ack", {7'd0, ack}, 8'h00);
      chk("both_done_cnt", done_cnt[7:0], 8'd5);

`ifdef I2C_TX_CLK_STRETCH_EN
      // 6: ACKed 12 stretches SCL until the next start
      send_byte(8'h12, 1'b0, seen);
      repeat (20) tick();
      chk("t6_stretch", {7'd0, scl_oe}, 8'h01);
      do_start(8'h34);
      chk("t6_release", {7'd0, scl_oe}, 8'h00);
      chk("t6_oe", {7'd0, sda_oe}, 8'h01);
      abort = 1'b1; tick(); abort = 1'b0; tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
